// File: rtl/lector_azules_pkg.sv
// Shared definitions for lector_azules: FSM encoding, counter-select constants
// and default widths.
package lector_azules_pkg;

   localparam int DATA_W_DEF = 12;
   localparam int CNT_W_DEF  = 5;
   localparam int N_CH       = 4;

   localparam logic [2:0] IDX_TOTAL = 3'd4;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_INIT   = 2'd1,
      ST_IDLE   = 2'd2,
      ST_ACTIVE = 2'd3
   } state_t;

   // Round-robin successor of a channel id.
   function automatic logic [1:0] next_ch(input logic [1:0] ch);
      return ch + 2'd1;
   endfunction

endpackage

// File: rtl/lector_azules_arbitro_rr.sv
// 4-way round-robin priority picker: first non-empty channel at or after i_ptr
// wins, producing a one-hot grant and its 2-bit id.
module arbitro_rr
   import lector_azules_pkg::*;
(
   input  logic [N_CH-1:0] i_empty,
   input  logic            i_en,
   input  logic [1:0]      i_ptr,
   output logic [N_CH-1:0] o_grant,
   output logic [1:0]      o_id,
   output logic            o_valid
);

   logic [N_CH-1:0] w_req;
   logic [N_CH-1:0] w_rot;
   logic [1:0]      w_sel [N_CH];
   logic            w_found;
   logic [1:0]      w_off;

   assign w_req = ~i_empty;

   // w_rot[k] is the request of channel ptr+k, so the lowest set bit is the winner.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
      assign w_sel[gi] = i_ptr + 2'(gi);
      assign w_rot[gi] = w_req[w_sel[gi]];
   end

   always_comb begin
      w_found = 1'b0;
      w_off   = 2'd0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_found = 1'b1;
            w_off   = 2'(k);
         end
      end
      o_id    = i_ptr + w_off;
      o_valid = i_en & w_found;
      o_grant = '0;
      if (o_valid) o_grant[o_id] = 1'b1;
   end

endmodule

// File: rtl/lector_azules.sv
// lector_azules: drains the four blue FIFOs round-robin into one downstream
// stream and keeps per-channel and total push counters readable via req/idx.
module lector_azules
   import lector_azules_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   init,
   input  logic [4*DATA_W-1:0]    data_azules,
   input  logic [3:0]             empty_azules,
   output logic [3:0]             pop_fifo_azules,
   input  logic                   almost_full_out,
   output logic [DATA_W-1:0]      data_out,
   output logic                   push_out,
   input  logic                   req,
   input  logic [2:0]             idx,
   output logic [CNT_W-1:0]       salida_contador,
   output logic                   valid_contador,
   output logic                   idle
);

   state_t            r_state;
   state_t            w_state_next;
   logic [1:0]        r_ptr;
   logic [N_CH-1:0]   w_grant;
   logic [1:0]        w_id;
   logic              w_pop;
   logic              w_en;
   logic              w_clear;
   logic              r_push;
   logic [1:0]        r_ch;
   logic [CNT_W-1:0]  r_cnt [N_CH];
   logic [CNT_W-1:0]  r_total;
   logic [CNT_W-1:0]  r_sal;
   logic              r_valid;
   logic              r_idle;
   logic [CNT_W-1:0]  w_rd_val;
   logic [DATA_W-1:0] w_slice [N_CH];

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_slice
      assign w_slice[gi] = data_azules[gi*DATA_W +: DATA_W];
   end

   assign w_en = (r_state == ST_ACTIVE) & ~almost_full_out;

   arbitro_rr u_arb (
      .i_empty (empty_azules),
      .i_en    (w_en),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_id    (w_id),
      .o_valid (w_pop)
   );

   assign pop_fifo_azules = w_grant;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RESET:  w_state_next = ST_RESET;
         ST_INIT:   if (!init) w_state_next = ST_IDLE;
         ST_IDLE:   if (!(&empty_azules)) w_state_next = ST_ACTIVE;
         ST_ACTIVE: if (&empty_azules) w_state_next = ST_IDLE;
         default:   w_state_next = ST_RESET;
      endcase
      if (init) w_state_next = ST_INIT;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_RESET;
         r_idle  <= 1'b0;
         r_ptr   <= 2'd0;
         r_push  <= 1'b0;
         r_ch    <= 2'd0;
      end else begin
         r_state <= w_state_next;
         r_idle  <= (w_state_next == ST_IDLE);
         r_push  <= w_pop;
         if (w_pop) begin
            r_ptr <= next_ch(w_id);
            r_ch  <= w_id;
         end
      end
   end

   // The FIFO presents popped data one cycle after the pop, i.e. in the push
   // cycle, so the registered channel id selects it directly.
   assign data_out = r_push ? w_slice[r_ch] : '0;
   assign push_out = r_push;

   // Clearing wins over an in-flight increment, including the last INIT cycle.
   assign w_clear = init | (r_state == ST_INIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
         r_total <= '0;
      end else if (w_clear) begin
         for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
         r_total <= '0;
      end else if (r_push) begin
         for (int i = 0; i < N_CH; i++) begin
            if (r_ch == 2'(i)) r_cnt[i] <= r_cnt[i] + 1'b1;
         end
         r_total <= r_total + 1'b1;
      end
   end

   always_comb begin
      w_rd_val = '0;
      if (idx < IDX_TOTAL)       w_rd_val = r_cnt[idx[1:0]];
      else if (idx == IDX_TOTAL) w_rd_val = r_total;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sal   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_sal   <= req ? w_rd_val : '0;
         r_valid <= req;
      end
   end

   assign salida_contador = r_sal;
   assign valid_contador  = r_valid;
   assign idle            = r_idle;

endmodule

// File: tb/tb_lector_azules.sv
// Self-checking bench for lector_azules: FIFO environment, cycle reference
// model, directed sequences, counter-read tables and a randomized phase.
module tb_lector_azules;

   logic        clk = 1'b0;
   logic        reset, init, almost_full_out, req;
   logic [2:0]  idx;
   logic [47:0] data_azules;
   logic [3:0]  empty_azules, pop_fifo_azules;
   logic [11:0] data_out;
   logic        push_out;
   logic [4:0]  salida_contador;
   logic        valid_contador, idle;

   always #5 clk = ~clk;

   lector_azules #(.DATA_W(12), .CNT_W(5)) dut (
      .clk             (clk),
      .reset           (reset),
      .init            (init),
      .data_azules     (data_azules),
      .empty_azules    (empty_azules),
      .pop_fifo_azules (pop_fifo_azules),
      .almost_full_out (almost_full_out),
      .data_out        (data_out),
      .push_out        (push_out),
      .req             (req),
      .idx             (idx),
      .salida_contador (salida_contador),
      .valid_contador  (valid_contador),
      .idle            (idle)
   );

   // FIFO environment: queue contents plus a registered read-data word per FIFO.
   logic [11:0] fq [4][$];
   logic [11:0] dout [4];

   // Reference model (modes named independently of the design).
   localparam int M_WAIT = 10, M_INIT = 11, M_IDLE = 12, M_RUN = 13;
   int          m_mode, m_ptr, m_total, m_push_ch, m_sal;
   int          m_cnt [4];
   bit          m_push, m_valid;
   logic [11:0] m_push_word;

   int errors = 0;
   int checks = 0;
   int pop_log[$];
   int push_seen = 0;

   typedef struct {
      int         phase;
      logic [2:0] ridx;
      int         exp;
   } rd_vec_t;
   rd_vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void drive_env();
      for (int c = 0; c < 4; c++) begin
         empty_azules[c]          = (fq[c].size() == 0);
         data_azules[c*12 +: 12]  = dout[c];
      end
   endfunction

   function automatic void model_reset();
      m_mode = M_WAIT; m_ptr = 0; m_total = 0; m_push = 0; m_push_ch = 0;
      m_push_word = '0; m_valid = 0; m_sal = 0;
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
   endfunction

   function automatic bit any_words();
      return (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) != 0;
   endfunction

   task automatic cycle();
      int          exp_ch, dut_ch, rd;
      logic [3:0]  dut_pop;
      @(negedge clk);
      #2;
      exp_ch = -1;
      if (!reset && m_mode == M_RUN && !almost_full_out)
         for (int k = 0; k < 4; k++)
            if (exp_ch < 0 && fq[(m_ptr + k) % 4].size() > 0) exp_ch = (m_ptr + k) % 4;
      chk("pop", pop_fifo_azules, (exp_ch < 0) ? 0 : (1 << exp_ch));
      chk("push_out", push_out, m_push);
      if (m_push) chk("data_out", data_out, m_push_word);
      chk("idle", idle, m_mode == M_IDLE);
      chk("valid_contador", valid_contador, m_valid);
      chk("salida_contador", salida_contador, m_sal);
      if (push_out === 1'b1) begin
         push_seen++;
         $display("push ch=%0d data=%03h t=%0t", m_push_ch, data_out, $time);
      end
      dut_pop = pop_fifo_azules;
      dut_ch  = -1;
      for (int c = 0; c < 4; c++) if (dut_pop[c]) dut_ch = c;
      if (dut_ch >= 0) pop_log.push_back(dut_ch);

      if (reset) begin
         model_reset();
      end else begin
         rd = 0;
         if (req) rd = (idx < 4) ? m_cnt[idx] : ((idx == 4) ? m_total : 0);
         if (init || m_mode == M_INIT) begin
            for (int c = 0; c < 4; c++) m_cnt[c] = 0;
            m_total = 0;
         end else if (m_push) begin
            m_cnt[m_push_ch] = (m_cnt[m_push_ch] + 1) % 32;
            m_total = (m_total + 1) % 32;
         end
         m_valid = req;
         m_sal   = rd;
         m_push  = (exp_ch >= 0);
         if (exp_ch >= 0) begin
            m_push_ch   = exp_ch;
            m_push_word = fq[exp_ch][0];
            m_ptr       = (exp_ch + 1) % 4;
         end
         if (init)                              m_mode = M_INIT;
         else if (m_mode == M_INIT)             m_mode = M_IDLE;
         else if (m_mode == M_IDLE && any_words())  m_mode = M_RUN;
         else if (m_mode == M_RUN && !any_words())  m_mode = M_IDLE;
      end

      @(posedge clk);
      #1;
      if (dut_ch >= 0 && fq[dut_ch].size() > 0) dout[dut_ch] = fq[dut_ch].pop_front();
      drive_env();
   endtask

   task automatic load(input int ch, input int n, input int base);
      for (int i = 0; i < n; i++) fq[ch].push_back(12'(base + i));
      drive_env();
   endtask

   task automatic init_pulse();
      init = 1'b1;
      cycle();
      cycle();
      init = 1'b0;
      cycle();
   endtask

   function automatic bit env_done();
      return !any_words() && idle === 1'b1 && push_out === 1'b0;
   endfunction

   task automatic run_until_idle(input int budget, input string name);
      int n = 0;
      while (!env_done() && n < budget) begin
         cycle();
         n++;
      end
      chk(name, env_done(), 1);
   endtask

   task automatic wait_pops(input int target, input int budget, input string name);
      int n = 0;
      while (pop_log.size() < target && n < budget) begin
         cycle();
         n++;
      end
      chk(name, pop_log.size() >= target, 1);
   endtask

   task automatic rd_check(input logic [2:0] i, input int exp);
      req = 1'b1;
      idx = i;
      cycle();
      req = 1'b0;
      chk($sformatf("rd_idx%0d", i), salida_contador, exp);
      chk($sformatf("rd_valid%0d", i), valid_contador, 1);
   endtask

   task automatic run_phase(input int p);
      foreach (tbl[i]) if (tbl[i].phase == p) rd_check(tbl[i].ridx, tbl[i].exp);
   endtask

   initial begin
      int p0, pb, pl;

      tbl.push_back('{0, 3'd0, 0}); tbl.push_back('{0, 3'd1, 0});
      tbl.push_back('{0, 3'd2, 0}); tbl.push_back('{0, 3'd3, 0});
      tbl.push_back('{0, 3'd4, 0}); tbl.push_back('{0, 3'd7, 0});
      tbl.push_back('{1, 3'd2, 5}); tbl.push_back('{1, 3'd4, 5});
      tbl.push_back('{1, 3'd0, 0});
      tbl.push_back('{2, 3'd1, 1}); tbl.push_back('{2, 3'd4, 1});
      tbl.push_back('{2, 3'd6, 0}); tbl.push_back('{2, 3'd5, 0});

      reset = 1'b1; init = 1'b0; almost_full_out = 1'b0; req = 1'b0; idx = 3'd0;
      for (int c = 0; c < 4; c++) dout[c] = '0;
      drive_env();
      model_reset();

      // Reset state, then init pulse into IDLE with all FIFOs empty.
      cycle();
      cycle();
      chk("rst_push", push_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_pop", pop_fifo_azules, 0);
      chk("rst_valid", valid_contador, 0);
      chk("rst_idle", idle, 0);
      reset = 1'b0;
      cycle();
      chk("wait_idle", idle, 0);
      init_pulse();
      cycle();
      chk("idle_after_init", idle, 1);
      chk("idle_no_pop", pop_fifo_azules, 0);
      run_phase(0);

      // Three words per channel: strict 0,1,2,3 rotation.
      pop_log.delete();
      for (int c = 0; c < 4; c++) load(c, 3, 'h800 + c * 16);
      run_until_idle(40, "rr_drain");
      chk("rr_count", pop_log.size(), 12);
      for (int i = 0; i < 12; i++)
         chk($sformatf("rr_order%0d", i), (pop_log.size() > i) ? pop_log[i] : -1, i % 4);

      // Backpressure after the second pop of a ch2-only burst.
      init_pulse();
      pop_log.delete();
      pb = push_seen;
      load(2, 5, 'h200);
      wait_pops(2, 10, "af_reach");
      almost_full_out = 1'b1;
      p0 = pop_log.size();
      repeat (3) cycle();
      chk("af_no_pop", pop_log.size() - p0, 0);
      chk("af_pushes", push_seen - pb, 2);
      almost_full_out = 1'b0;
      run_until_idle(20, "af_drain");
      run_phase(1);

      // 33 words through ch1: 5-bit counters wrap.
      init_pulse();
      load(1, 33, 'h100);
      run_until_idle(60, "wrap_drain");
      run_phase(2);

      // init while ACTIVE with a word in flight.
      init_pulse();
      pop_log.delete();
      load(0, 2, 'h300);
      load(3, 2, 'h330);
      wait_pops(1, 10, "init_reach");
      pb = push_seen;
      init = 1'b1;
      cycle();
      cycle();
      chk("init_inflight", push_seen - pb, 2);
      rd_check(3'd4, 0);
      rd_check(3'd0, 0);
      init = 1'b0;
      pl = pop_log.size();
      run_until_idle(20, "init_drain");
      chk("resume_ch", (pop_log.size() > pl) ? pop_log[pl] : -1, 3);

      // Randomized traffic against the model.
      init_pulse();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            int ch = $urandom_range(0, 3);
            int cnt = $urandom_range(1, 3);
            for (int w = 0; w < cnt; w++) fq[ch].push_back(12'($urandom_range(0, 4095)));
            drive_env();
         end
         almost_full_out = ($urandom_range(0, 3) == 0);
         req  = ($urandom_range(0, 1) == 1);
         idx  = 3'($urandom_range(0, 7));
         init = ($urandom_range(0, 49) == 0);
         cycle();
      end
      init = 1'b0; almost_full_out = 1'b0; req = 1'b0;
      cycle();
      run_until_idle(600, "rand_drain");

      // Reset one cycle after a pop discards the in-flight word.
      pop_log.delete();
      load(0, 3, 'h500);
      wait_pops(1, 10, "rst_reach");
      reset = 1'b1;
      #1;
      chk("mid_rst_push", push_out, 0);
      chk("mid_rst_data", data_out, 0);
      chk("mid_rst_pop", pop_fifo_azules, 0);
      chk("mid_rst_idle", idle, 0);
      chk("mid_rst_valid", valid_contador, 0);
      chk("mid_rst_sal", salida_contador, 0);
      model_reset();
      cycle();
      reset = 1'b0;
      p0 = pop_log.size();
      repeat (3) cycle();
      chk("rst_hold_nopop", pop_log.size() - p0, 0);
      chk("rst_hold_idle", idle, 0);
      init_pulse();
      run_until_idle(20, "rst_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
